// File: rtl/rr_mux2_arbiter.sv
// Two-source round-robin arbiter feeding a single registered valid/ready output stage.
// Define ARB_PKT_LOCK_EN to hold the grant on one source until its packet's last beat.
module rr_mux2_arbiter #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in0_data,
    input  logic          in0_valid,
    input  logic          in0_last,
    output logic          in0_ready,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_valid,
    input  logic          in1_last,
    output logic          in1_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          sel
);

    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;

    logic          accept;
    logic          gnt_valid;
    logic          gnt_idx;
    logic          gnt_last;
    logic          xfer;

`ifdef ARB_PKT_LOCK_EN
    typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;
    state_e state_q, state_d;
`endif

    // Returns {grant valid, grant index}; ties go to prio.
    function automatic logic [1:0] arbitrate(input logic v0, input logic v1, input logic p);
        logic [1:0] r;
        r = 2'b00;
        if (v0 && v1)  r = {1'b1, p};
        else if (v0)   r = 2'b10;
        else if (v1)   r = 2'b11;
        return r;
    endfunction

    assign accept = !out_valid_q || out_ready;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
`ifdef ARB_PKT_LOCK_EN
        case (state_q)
            StLock0: begin
                gnt_idx   = 1'b0;
                gnt_valid = in0_valid;
            end
            StLock1: begin
                gnt_idx   = 1'b1;
                gnt_valid = in1_valid;
            end
            default: {gnt_valid, gnt_idx} = arbitrate(in0_valid, in1_valid, prio_q);
        endcase
`else
        {gnt_valid, gnt_idx} = arbitrate(in0_valid, in1_valid, prio_q);
`endif
    end

    assign xfer      = accept && gnt_valid;
    assign gnt_last  = gnt_idx ? in1_last : in0_last;
    // Nothing is accepted while reset is held.
    assign in0_ready = rst_n && xfer && !gnt_idx;
    assign in1_ready = rst_n && xfer && gnt_idx;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        sel_d       = sel_q;
        prio_d      = prio_q;
`ifdef ARB_PKT_LOCK_EN
        state_d     = state_q;
`endif
        if (xfer) begin
            out_data_d  = gnt_idx ? in1_data : in0_data;
            out_last_d  = gnt_last;
            sel_d       = gnt_idx;
            out_valid_d = 1'b1;
`ifdef ARB_PKT_LOCK_EN
            case (state_q)
                StIdle: begin
                    prio_d = ~gnt_idx;
                    if (!gnt_last) state_d = gnt_idx ? StLock1 : StLock0;
                end
                default: begin
                    if (gnt_last) begin
                        state_d = StIdle;
                        prio_d  = ~gnt_idx;
                    end
                end
            endcase
`else
            prio_d = ~gnt_idx;
`endif
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            sel_q       <= 1'b0;
            prio_q      <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
            state_q     <= StIdle;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            sel_q       <= sel_d;
            prio_q      <= prio_d;
`ifdef ARB_PKT_LOCK_EN
            state_q     <= state_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_rr_mux2_arbiter.sv
// Bench for rr_mux2_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_rr_mux2_arbiter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] in0_data = '0, in1_data = '0;
    logic          in0_valid = 1'b0, in1_valid = 1'b0;
    logic          in0_last = 1'b0, in1_last = 1'b0;
    logic          in0_ready, in1_ready;
    logic [DW-1:0] out_data;
    logic          out_valid, out_last, sel;
    logic          out_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference state: what the output stage should hold, round-robin pointer, lock owner.
    int m_valid, m_data, m_last, m_sel, m_prio, m_lock;
    int last_grant;

    rr_mux2_arbiter #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0_data (in0_data),
        .in0_valid(in0_valid),
        .in0_last (in0_last),
        .in0_ready(in0_ready),
        .in1_data (in1_data),
        .in1_valid(in1_valid),
        .in1_last (in1_last),
        .in1_ready(in1_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_last (out_last),
        .out_ready(out_ready),
        .sel      (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_lock >= 0) return ((m_lock == 0 ? in0_valid : in1_valid) ? m_lock : -1);
        if (in0_valid && in1_valid) return m_prio;
        if (in0_valid) return 0;
        if (in1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_data = 0; m_last = 0; m_sel = 0; m_prio = 0; m_lock = -1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ":out_valid"}, out_valid, m_valid);
        chk({tag, ":out_data"}, out_data, m_data);
        chk({tag, ":out_last"}, out_last, m_last);
        chk({tag, ":sel"}, sel, m_sel);
    endtask

    // One clock: starts at negedge with inputs driven, ends at the following negedge.
    task automatic step(input string tag);
        int g, lst;
        bit acc;
        #1;
        acc = (m_valid == 0) || out_ready;
        g = acc ? model_grant() : -1;
        chk({tag, ":in0_ready"}, in0_ready, g == 0);
        chk({tag, ":in1_ready"}, in1_ready, g == 1);
        @(posedge clk);
        #1;
        if (g >= 0) begin
            lst     = (g == 0) ? in0_last : in1_last;
            m_valid = 1;
            m_data  = (g == 0) ? in0_data : in1_data;
            m_last  = lst;
            m_sel   = g;
`ifdef ARB_PKT_LOCK_EN
            if (m_lock < 0) begin
                m_prio = 1 - g;
                if (lst == 0) m_lock = g;
            end else if (lst != 0) begin
                m_lock = -1;
                m_prio = 1 - g;
            end
`else
            m_prio = 1 - g;
`endif
        end else if (acc) begin
            m_valid = 0;
        end
        last_grant = g;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic drive(input bit v0, input int d0, input bit l0,
                         input bit v1, input int d1, input bit l1, input bit ordy);
        in0_valid = v0; in0_data = d0[DW-1:0]; in0_last = l0;
        in1_valid = v1; in1_data = d1[DW-1:0]; in1_last = l1;
        out_ready = ordy;
    endtask

    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ":rst_in0_ready"}, in0_ready, 0);
        chk({tag, ":rst_in1_ready"}, in1_ready, 0);
        check_outputs({tag, ":rst"});
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit hold0, hold1;
        model_reset();
        @(negedge clk);

        // Reset state, then release.
        apply_reset("init");

        // Single source streams three beats.
        drive(1, 8'h11, 0, 0, 0, 0, 1); step("t2a"); chk("t2a_data", out_data, 8'h11);
        drive(1, 8'h22, 0, 0, 0, 0, 1); step("t2b"); chk("t2b_data", out_data, 8'h22);
        drive(1, 8'h33, 1, 0, 0, 0, 1); step("t2c"); chk("t2c_data", out_data, 8'h33);
        chk("t2c_sel", sel, 0);

        // Mid-stream reset with out_valid high and sources still valid.
        drive(1, 8'h44, 1, 1, 8'h55, 1, 0);
        #2 apply_reset("t1");

        // Contention: grants alternate starting with in0.
        for (int i = 0; i < 4; i++) begin
            drive(1, 8'hA0 + i, 1, 1, 8'hB0 + i, 1, 1);
            step("t3");
            chk("t3_sel", sel, i % 2);
        end

        // Backpressure: held beat, no readys, then consumed exactly once.
        drive(1, 8'hC0, 1, 0, 0, 0, 1); step("t4_load");
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'hC1, 1, 1, 8'hD1, 1, 0);
            step("t4_hold");
            chk("t4_held", out_data, 8'hC0);
        end
        drive(1, 8'hC1, 1, 1, 8'hD1, 1, 1); step("t4_rel");
        drive(0, 0, 0, 0, 0, 0, 1); step("t4_drain");

        // Packet: in0 three beats with in1 pending throughout.
        apply_reset("t5");
        for (int i = 0; i < 4; i++) begin
            drive(i < 3, 8'h60 + i, i == 2, 1, 8'h70, 1, 1);
            step("t5");
`ifdef ARB_PKT_LOCK_EN
            chk("t5_sel", sel, i == 3);
`endif
        end

        // Idle gap: output drains, then in1 wins even though prio favours in0.
        drive(0, 0, 0, 1, 8'h81, 1, 1); step("t6_beat");
        drive(0, 0, 0, 0, 0, 0, 1); step("t6_gap");
        chk("t6_drained", out_valid, 0);
        drive(0, 0, 0, 1, 8'h82, 1, 1); step("t6_in1");
        chk("t6_sel", sel, 1);

        // Random traffic; an ungranted beat is held stable as a real source would.
        hold0 = 0; hold1 = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold0) begin
                in0_valid = ($urandom_range(0, 1) == 1);
                in0_data  = DW'($urandom);
                in0_last  = ($urandom_range(0, 2) == 0);
            end
            if (!hold1) begin
                in1_valid = ($urandom_range(0, 1) == 1);
                in1_data  = DW'($urandom);
                in1_last  = ($urandom_range(0, 2) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step("rnd");
            hold0 = in0_valid && (last_grant != 0);
            hold1 = in1_valid && (last_grant != 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
